// File: rtl/ioctl_byte_source.sv
// Word FIFO to paced byte-wide ioctl download stream for the ROM loader path.
// Define IOCTL_SRC_LSB_FIRST_EN for LSB-first byte order within each word.
module ioctl_byte_source #(
  parameter int FIFO_DEPTH = 16,
  parameter int WR_GAP     = 4
) (
  input  logic        clk,
  input  logic        RSTn,
  input  logic        slot_start,
  input  logic [15:0] slot_index,
  input  logic        slot_end,
  input  logic        word_valid,
  input  logic [24:0] word_addr,
  input  logic [31:0] word_data,
  output logic        fifo_full,
  output logic        overflow,
  output logic        busy,
  output logic        ioctl_download,
  output logic [15:0] ioctl_index,
  output logic        ioctl_wr,
  output logic [24:0] ioctl_addr,
  output logic [7:0]  ioctl_data,
  input  logic        ioctl_wait
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ACTIVE, S_LOAD, S_EMIT, S_GAP, S_DRAIN
  } state_t;

  state_t r_state, w_next;

  logic [54:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic [22:0]   r_waddr;
  logic [31:0]   r_word;
  logic [1:0]    r_cnt;
  logic [GW-1:0] r_gap;
  logic          r_end, r_ovf, r_dl;
  logic [15:0]   r_index;
  logic [24:0]   r_addr;
  logic [7:0]    r_data;

  logic          w_push, w_pop, w_empty, w_end, w_gap_done;
  logic [54:0]   w_head;
  logic [1:0]    w_cnt_nx;
  logic          w_unused;

  function automatic logic [7:0] f_byte(input logic [31:0] w,
                                        input logic [1:0]  c);
`ifdef IOCTL_SRC_LSB_FIRST_EN
    f_byte = w[{c, 3'b000} +: 8];
`else
    f_byte = w[{~c, 3'b000} +: 8];
`endif
  endfunction

  assign w_unused   = ^word_addr[1:0];
  assign fifo_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_push     = word_valid && !fifo_full && (r_state != S_IDLE);
  assign w_pop      = (r_state == S_LOAD);
  assign w_head     = r_mem[r_rptr];
  assign w_end      = r_end || slot_end;
  assign w_gap_done = (r_gap == GW'(WR_GAP - 1));
  assign w_cnt_nx   = r_cnt + 2'd1;

  assign overflow       = r_ovf;
  assign busy           = (r_state != S_IDLE);
  assign ioctl_download = r_dl;
  assign ioctl_index    = r_index;
  assign ioctl_wr       = (r_state == S_EMIT) && !ioctl_wait;
  assign ioctl_addr     = r_addr;
  assign ioctl_data     = r_data;

  // ACTIVE holds off the pop while the sink stalls, so queued words stay counted
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (slot_start) w_next = S_ACTIVE;
      S_ACTIVE: begin
        if (!w_empty) begin
          if (!ioctl_wait) w_next = S_LOAD;
        end else if (w_end) begin
          w_next = S_IDLE;
        end
      end
      S_LOAD:   w_next = S_EMIT;
      S_EMIT:   if (!ioctl_wait) w_next = S_GAP;
      S_GAP: begin
        if (w_gap_done) begin
          if (r_cnt != 2'd3)  w_next = S_EMIT;
          else if (!w_empty)  w_next = S_LOAD;
          else if (w_end)     w_next = S_DRAIN;
          else                w_next = S_ACTIVE;
        end
      end
      S_DRAIN:  w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {word_addr[24:2], word_data};
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= S_IDLE;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_waddr <= '0;
      r_word  <= '0;
      r_cnt   <= '0;
      r_gap   <= '0;
      r_end   <= 1'b0;
      r_ovf   <= 1'b0;
      r_dl    <= 1'b0;
      r_index <= '0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_next;
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);

      if (r_state == S_IDLE) r_end <= 1'b0;
      else if (slot_end)     r_end <= 1'b1;

      if (r_state == S_IDLE && slot_start) begin
        r_index <= slot_index;
        r_ovf   <= 1'b0;
        r_dl    <= 1'b1;
      end else begin
        if (word_valid && fifo_full && r_state != S_IDLE) r_ovf <= 1'b1;
        if ((r_state == S_ACTIVE && w_next == S_IDLE) ||
            r_state == S_DRAIN)
          r_dl <= 1'b0;
      end

      if (r_state == S_EMIT) r_gap <= '0;
      else if (r_state == S_GAP) r_gap <= r_gap + GW'(1);

      if (r_state == S_LOAD) begin
        r_waddr <= w_head[54:32];
        r_word  <= w_head[31:0];
        r_cnt   <= 2'd0;
        r_addr  <= {w_head[54:32], 2'd0};
        r_data  <= f_byte(w_head[31:0], 2'd0);
      end else if (r_state == S_GAP && w_next == S_EMIT) begin
        r_cnt   <= w_cnt_nx;
        r_addr  <= {r_waddr, w_cnt_nx};
        r_data  <= f_byte(r_word, w_cnt_nx);
      end
    end
  end

endmodule

// File: tb/tb_ioctl_byte_source.sv
// Directed bench for ioctl_byte_source: ordering, pacing, back-pressure,
// overflow, end-of-slot drain and mid-stream reset.
module tb_ioctl_byte_source;

  logic        clk = 1'b0;
  logic        RSTn = 1'b0;
  logic        slot_start = 1'b0;
  logic [15:0] slot_index = '0;
  logic        slot_end = 1'b0;
  logic        word_valid = 1'b0;
  logic [24:0] word_addr = '0;
  logic [31:0] word_data = '0;
  logic        fifo_full, overflow, busy;
  logic        ioctl_download, ioctl_wr;
  logic [15:0] ioctl_index;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wait = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  int          got;
  int          p_cyc  [64];
  logic [24:0] p_addr [64];
  logic [7:0]  p_data [64];
  logic        p_dl   [64];

  ioctl_byte_source #(.FIFO_DEPTH(16), .WR_GAP(4)) dut (
    .clk(clk), .RSTn(RSTn),
    .slot_start(slot_start), .slot_index(slot_index),
    .slot_end(slot_end), .word_valid(word_valid),
    .word_addr(word_addr), .word_data(word_data),
    .fifo_full(fifo_full), .overflow(overflow), .busy(busy),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_data(ioctl_data), .ioctl_wait(ioctl_wait)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached, got 0 required finish");
    $fatal(1);
  end

  function automatic logic [7:0] exp_byte(input logic [31:0] w, input int j);
    logic [31:0] s;
`ifdef IOCTL_SRC_LSB_FIRST_EN
    s = w >> (8 * j);
`else
    s = w >> (8 * (3 - j));
`endif
    return s[7:0];
  endfunction

  task automatic collect(input int n, input int budget);
    got = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      @(negedge clk); #1;
      if (ioctl_wr === 1'b1) begin
        p_cyc[got]  = cyc;
        p_addr[got] = ioctl_addr;
        p_data[got] = ioctl_data;
        p_dl[got]   = ioctl_download;
        got++;
      end
    end
  endtask

  task automatic wait_dl_low(input int budget);
    for (int c = 0; c < budget && ioctl_download === 1'b1; c++) begin
      @(negedge clk); #1;
    end
  endtask

  task automatic start_slot(input logic [15:0] idx);
    @(negedge clk);
    slot_index = idx;
    slot_start = 1'b1;
    @(negedge clk);
    slot_start = 1'b0;
  endtask

  task automatic test_reset;
    RSTn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({fifo_full, overflow, busy, ioctl_download, ioctl_wr} !== 5'b0 ||
        ioctl_index !== 16'h0 || ioctl_addr !== 25'h0 ||
        ioctl_data !== 8'h0) begin
      n_errors++;
      $display("FAIL reset_outputs: got flags=%b idx=%h addr=%h data=%h required all 0",
               {fifo_full, overflow, busy, ioctl_download, ioctl_wr},
               ioctl_index, ioctl_addr, ioctl_data);
    end
    @(negedge clk);
    RSTn = 1'b1;
  endtask

  task automatic test_basic;
    int k;
    start_slot(16'd0);
    #1;
    n_checks++;
    if (ioctl_download !== 1'b1 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL t1_window: got dl=%b busy=%b required 1 1",
               ioctl_download, busy);
    end
    k = cyc;
    word_addr  = 25'h0;
    word_data  = 32'h11223344;
    word_valid = 1'b1;
    @(negedge clk);
    word_valid = 1'b0;
    slot_end   = 1'b1;
    @(negedge clk);
    slot_end = 1'b0;
    collect(4, 100);
    n_checks++;
    if (got !== 4) begin
      n_errors++;
      $display("FAIL t1_count: got %0d pulses required 4", got);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (p_data[i] !== exp_byte(32'h11223344, i) ||
          p_addr[i] !== 25'(i)) begin
        n_errors++;
        $display("FAIL t1_byte%0d: got %h@%h required %h@%h", i,
                 p_data[i], p_addr[i], exp_byte(32'h11223344, i), 25'(i));
      end
    end
    n_checks++;
    if (p_cyc[0] !== k + 3) begin
      n_errors++;
      $display("FAIL t1_latency: got cycle %0d required %0d", p_cyc[0], k + 3);
    end
    for (int i = 1; i < 4; i++) begin
      n_checks++;
      if (p_cyc[i] - p_cyc[i-1] !== 5) begin
        n_errors++;
        $display("FAIL t1_spacing%0d: got %0d required 5", i,
                 p_cyc[i] - p_cyc[i-1]);
      end
    end
    wait_dl_low(50);
    n_checks++;
    if (ioctl_download !== 1'b0 || cyc !== p_cyc[3] + 6 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL t1_dl_drop: got dl=%b busy=%b cyc=%0d required 0 0 %0d",
               ioctl_download, busy, cyc, p_cyc[3] + 6);
    end
  endtask

  task automatic test_wait;
    int viol;
    start_slot(16'd2);
    word_addr  = 25'h100;
    word_data  = 32'h11223344;
    word_valid = 1'b1;
    @(negedge clk);
    word_valid = 1'b0;
    collect(2, 50);
    n_checks++;
    if (got !== 2) begin
      n_errors++;
      $display("FAIL t2_pre: got %0d pulses required 2", got);
    end
    @(negedge clk);
    ioctl_wait = 1'b1;
    viol = 0;
    repeat (20) begin
      @(negedge clk); #1;
      if (ioctl_wr !== 1'b0) viol++;
    end
    n_checks++;
    if (viol !== 0) begin
      n_errors++;
      $display("FAIL t2_blocked: got %0d pulses required 0", viol);
    end
    n_checks++;
    if (ioctl_data !== 8'h33 || ioctl_addr !== 25'h102) begin
      n_errors++;
      $display("FAIL t2_held: got %h@%h required 33@102", ioctl_data, ioctl_addr);
    end
    @(negedge clk);
    ioctl_wait = 1'b0;
    #1;
    n_checks++;
    if (ioctl_wr !== 1'b1 || ioctl_data !== 8'h33) begin
      n_errors++;
      $display("FAIL t2_release: got wr=%b data=%h required 1 33",
               ioctl_wr, ioctl_data);
    end
    @(negedge clk);
    slot_end = 1'b1;
    @(negedge clk);
    slot_end = 1'b0;
    collect(1, 50);
    n_checks++;
    if (got !== 1 || p_data[0] !== 8'h44 || p_addr[0] !== 25'h103) begin
      n_errors++;
      $display("FAIL t2_last: got n=%0d %h@%h required 1 44@103",
               got, p_data[0], p_addr[0]);
    end
    wait_dl_low(50);
  endtask

  task automatic test_overflow;
    logic [31:0] dw [17];
    logic [24:0] base;
    logic [24:0] ea;
    int nbad;
    base = 25'h1FFFFF0;
    for (int i = 0; i < 17; i++)
      dw[i] = 32'h10203040 + 32'h01010101 * 32'(i);
    @(negedge clk);
    slot_index = 16'd3;
    slot_start = 1'b1;
    ioctl_wait = 1'b1;
    @(negedge clk);
    slot_start = 1'b0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      word_valid = 1'b1;
      word_addr  = base + 25'(4 * i) + 25'(i % 4);
      word_data  = dw[i];
      if (i == 16) begin
        #1;
        n_checks++;
        if (fifo_full !== 1'b1 || overflow !== 1'b0) begin
          n_errors++;
          $display("FAIL t3_full16: got full=%b ovf=%b required 1 0",
                   fifo_full, overflow);
        end
      end
    end
    @(negedge clk);
    word_valid = 1'b0;
    #1;
    n_checks++;
    if (fifo_full !== 1'b1 || overflow !== 1'b1) begin
      n_errors++;
      $display("FAIL t3_ovf: got full=%b ovf=%b required 1 1",
               fifo_full, overflow);
    end
    @(negedge clk);
    ioctl_wait = 1'b0;
    slot_end   = 1'b1;
    @(negedge clk);
    slot_end = 1'b0;
    collect(64, 700);
    n_checks++;
    if (got !== 64) begin
      n_errors++;
      $display("FAIL t3_count: got %0d bytes required 64", got);
    end
    nbad = 0;
    for (int i = 0; i < 64; i++) begin
      ea = base + 25'(i);
      if (p_addr[i] !== ea || p_data[i] !== exp_byte(dw[i / 4], i % 4)) begin
        if (nbad == 0)
          $display("FAIL t3_stream: byte %0d got %h@%h required %h@%h", i,
                   p_data[i], p_addr[i], exp_byte(dw[i / 4], i % 4), ea);
        nbad++;
      end
    end
    n_checks++;
    if (nbad !== 0) begin
      n_errors++;
      $display("FAIL t3_stream_total: got %0d bad bytes required 0", nbad);
    end
    wait_dl_low(50);
    n_checks++;
    if (ioctl_download !== 1'b0 || fifo_full !== 1'b0) begin
      n_errors++;
      $display("FAIL t3_end: got dl=%b full=%b required 0 0",
               ioctl_download, fifo_full);
    end
  endtask

  task automatic test_drain;
    int ndl;
    @(negedge clk);
    slot_index = 16'd4;
    slot_start = 1'b1;
    ioctl_wait = 1'b1;
    @(negedge clk);
    slot_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      word_valid = 1'b1;
      word_addr  = 25'h200 + 25'(4 * i);
      word_data  = 32'hA5A50000 + 32'(i);
    end
    @(negedge clk);
    word_valid = 1'b0;
    slot_end   = 1'b1;
    @(negedge clk);
    slot_end   = 1'b0;
    ioctl_wait = 1'b0;
    collect(12, 200);
    n_checks++;
    if (got !== 12) begin
      n_errors++;
      $display("FAIL t4_count: got %0d pulses required 12", got);
    end
    ndl = 0;
    for (int i = 0; i < 12; i++) if (p_dl[i] !== 1'b1) ndl++;
    n_checks++;
    if (ndl !== 0) begin
      n_errors++;
      $display("FAIL t4_window: got %0d pulses outside window required 0", ndl);
    end
    n_checks++;
    if (p_data[11] !== exp_byte(32'hA5A50002, 3) || p_addr[11] !== 25'h20B) begin
      n_errors++;
      $display("FAIL t4_last: got %h@%h required %h@20b",
               p_data[11], p_addr[11], exp_byte(32'hA5A50002, 3));
    end
    wait_dl_low(50);
    n_checks++;
    if (ioctl_download !== 1'b0 || busy !== 1'b0 || cyc !== p_cyc[11] + 6) begin
      n_errors++;
      $display("FAIL t4_drain: got dl=%b busy=%b cyc=%0d required 0 0 %0d",
               ioctl_download, busy, cyc, p_cyc[11] + 6);
    end
  endtask

  task automatic test_reset_mid;
    int nwr;
    start_slot(16'd7);
    for (int i = 0; i < 2; i++) begin
      word_valid = 1'b1;
      word_addr  = 25'h300 + 25'(4 * i);
      word_data  = 32'hCAFEF00D;
      @(negedge clk);
    end
    word_valid = 1'b0;
    collect(1, 50);
    @(negedge clk);
    RSTn = 1'b0;
    #1;
    n_checks++;
    if ({fifo_full, overflow, busy, ioctl_download, ioctl_wr} !== 5'b0 ||
        ioctl_index !== 16'h0 || ioctl_addr !== 25'h0 ||
        ioctl_data !== 8'h0) begin
      n_errors++;
      $display("FAIL t5_async: got flags=%b idx=%h addr=%h data=%h required all 0",
               {fifo_full, overflow, busy, ioctl_download, ioctl_wr},
               ioctl_index, ioctl_addr, ioctl_data);
    end
    nwr = 0;
    repeat (3) begin
      @(negedge clk); #1;
      if (ioctl_wr !== 1'b0) nwr++;
    end
    RSTn = 1'b1;
    n_checks++;
    if (nwr !== 0) begin
      n_errors++;
      $display("FAIL t5_quiet: got %0d pulses in reset required 0", nwr);
    end
    start_slot(16'd5);
    word_valid = 1'b1;
    word_addr  = 25'h40;
    word_data  = 32'hA1B2C3D4;
    @(negedge clk);
    word_valid = 1'b0;
    slot_end   = 1'b1;
    @(negedge clk);
    slot_end = 1'b0;
    collect(5, 80);
    n_checks++;
    if (got !== 4) begin
      n_errors++;
      $display("FAIL t5_count: got %0d pulses required 4", got);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (p_data[i] !== exp_byte(32'hA1B2C3D4, i) ||
          p_addr[i] !== 25'h40 + 25'(i)) begin
        n_errors++;
        $display("FAIL t5_byte%0d: got %h@%h required %h@%h", i,
                 p_data[i], p_addr[i], exp_byte(32'hA1B2C3D4, i),
                 25'h40 + 25'(i));
      end
    end
    n_checks++;
    if (ioctl_index !== 16'd5 || ioctl_download !== 1'b0) begin
      n_errors++;
      $display("FAIL t5_index: got idx=%0d dl=%b required 5 0",
               ioctl_index, ioctl_download);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait();
    test_overflow();
    test_drain();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
